// File: rtl/register_file_x_pkg.sv
// Shared constants for the MSP430X-style register file.
// Provides register indices, SR bit positions, operand size encodings,
// the step-calculator role type and a size normalisation helper.
package register_file_x_pkg;

  localparam int unsigned RIDX_W = 4;

  // Architectural register indices (SR doubles as constant generator CG1)
  localparam logic [RIDX_W-1:0] REG_PC  = 4'd0;
  localparam logic [RIDX_W-1:0] REG_SP  = 4'd1;
  localparam logic [RIDX_W-1:0] REG_SR  = 4'd2;
  localparam logic [RIDX_W-1:0] REG_CG1 = 4'd2;
  localparam logic [RIDX_W-1:0] REG_CG2 = 4'd3;

  // Status register bit positions
  localparam int unsigned SR_C   = 0;
  localparam int unsigned SR_Z   = 1;
  localparam int unsigned SR_N   = 2;
  localparam int unsigned SR_GIE = 3;
  localparam int unsigned SR_V   = 8;
  localparam int unsigned SR_W   = 9;

  // Operand size encodings
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_W = 2'b01;
  localparam logic [1:0] SZ_A = 2'b10;

  // Autoincrement (@Rn+) vs stack push/pop stepping
  typedef enum logic {
    ROLE_AUTO  = 1'b0,
    ROLE_STACK = 1'b1
  } step_role_e;

  // Encoding 11 behaves as word; address-word collapses to word on 16-bit cores
  function automatic logic [1:0] norm_size(input logic [1:0] size, input int unsigned data_w);
    if (size == SZ_B) return SZ_B;
    if (size == SZ_A && data_w > 16) return SZ_A;
    return SZ_W;
  endfunction

endpackage

// File: rtl/register_file_x_step_calc.sv
// rf_step_calc: maps (register index, operand size, role) to the increment
// step and the size/register-masked writeback value.
//   idx    - register the step or writeback applies to
//   size   - operand size (00 byte, 01 word, 10 address-word, 11 word)
//   role   - ROLE_AUTO for @Rn+ stepping, ROLE_STACK for SP push/pop
//   value  - raw writeback value
//   step_c - increment amount (0 for non-incrementable registers)
//   wb_c   - value after size and per-register masking
module rf_step_calc
  import register_file_x_pkg::*;
#(
  parameter int unsigned DATA_W = 20
) (
  input  logic [RIDX_W-1:0] idx,
  input  logic [1:0]        size,
  input  step_role_e        role,
  input  logic [DATA_W-1:0] value,
  output logic [DATA_W-1:0] step_c,
  output logic [DATA_W-1:0] wb_c
);

  logic [1:0] sz;
  logic [2:0] step3;

  always_comb begin
    sz    = norm_size(size, DATA_W);
    step3 = 3'd2;
    wb_c  = DATA_W'(value[15:0]);
    case (sz)
      SZ_B: begin
        step3 = 3'd1;
        wb_c  = DATA_W'(value[7:0]);
      end
      SZ_A: begin
        step3 = 3'd4;
        wb_c  = value;
      end
      default: begin
        step3 = 3'd2;
        wb_c  = DATA_W'(value[15:0]);
      end
    endcase

    // PC and SP stay word aligned; SR/CG1 and CG2 never step
    if (role == ROLE_STACK) begin
      step3 = (sz == SZ_A) ? 3'd4 : 3'd2;
    end else if (idx == REG_PC || idx == REG_SP) begin
      if (step3 == 3'd1) step3 = 3'd2;
    end else if (idx == REG_CG1 || idx == REG_CG2) begin
      step3 = 3'd0;
    end

    if (idx == REG_PC || idx == REG_SP) wb_c[0] = 1'b0;
    if (idx == REG_SR) wb_c = wb_c & DATA_W'(9'h1FF);

    step_c = DATA_W'(step3);
  end

endmodule

// File: rtl/register_file_x.sv
// register_file_x: MSP430X-style CPU register file with size-aware
// writeback, autoincrement, SP push/pop and a sticky update-conflict flag.
//   clk, rst (async, active low)
//   if_inc/idx_inc/sp_dec/sp_inc/intack/ex - sequencer strobes
//   isr_vec, sr_new, src_a, dst_a, size, src_inc, dst_inc, rw, result - operands/control
//   pc, sp, rsrc, rdst, sr_flags, gie - combinational reads of the registers
//   conflict - sticky flag, cleared only by reset
module register_file_x
  import register_file_x_pkg::*;
#(
  parameter int unsigned       DATA_W   = 20,
  parameter int unsigned       NREG     = 16,
  parameter logic [DATA_W-1:0] PC_RESET = '0,
  parameter logic [DATA_W-1:0] SP_RESET = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_inc,
  input  logic              idx_inc,
  input  logic              sp_dec,
  input  logic              sp_inc,
  input  logic              intack,
  input  logic [DATA_W-1:0] isr_vec,
  input  logic              ex,
  input  logic [3:0]        sr_new,
  input  logic [RIDX_W-1:0] src_a,
  input  logic [RIDX_W-1:0] dst_a,
  input  logic [1:0]        size,
  input  logic              src_inc,
  input  logic              dst_inc,
  input  logic              rw,
  input  logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] pc,
  output logic [DATA_W-1:0] sp,
  output logic [DATA_W-1:0] rsrc,
  output logic [DATA_W-1:0] rdst,
  output logic [3:0]        sr_flags,
  output logic              gie,
  output logic              conflict
);

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] regs_d [NREG];
  logic              conflict_q, conflict_d;

  logic [DATA_W-1:0] src_step, dst_step, sp_step, dst_wb;
  logic [DATA_W-1:0] src_wb_unused, sp_wb_unused;

  rf_step_calc #(.DATA_W(DATA_W)) u_src_step (
    .idx(src_a), .size(size), .role(ROLE_AUTO), .value(result),
    .step_c(src_step), .wb_c(src_wb_unused)
  );

  rf_step_calc #(.DATA_W(DATA_W)) u_dst_step (
    .idx(dst_a), .size(size), .role(ROLE_AUTO), .value(result),
    .step_c(dst_step), .wb_c(dst_wb)
  );

  rf_step_calc #(.DATA_W(DATA_W)) u_sp_step (
    .idx(REG_SP), .size(size), .role(ROLE_STACK), .value(result),
    .step_c(sp_step), .wb_c(sp_wb_unused)
  );

  // Per-register next value: writeback > dst_inc > src_inc > implicit, intack on top
  always_comb begin
    conflict_d = conflict_q;
    for (int i = 0; i < NREG; i++) begin
      regs_d[i] = regs_q[i];
      if (rw && dst_a == RIDX_W'(i) && dst_a != REG_CG2) begin
        regs_d[i] = dst_wb;
      end else if (dst_inc && dst_a == RIDX_W'(i) && dst_step != '0) begin
        regs_d[i] = regs_q[i] + dst_step;
      end else if (src_inc && src_a == RIDX_W'(i) && src_step != '0) begin
        regs_d[i] = regs_q[i] + src_step;
      end else if (RIDX_W'(i) == REG_PC && (if_inc || idx_inc)) begin
        regs_d[i] = regs_q[i] + DATA_W'(2);
      end else if (RIDX_W'(i) == REG_SP && (sp_dec != sp_inc)) begin
        regs_d[i] = sp_dec ? (regs_q[i] - sp_step) : (regs_q[i] + sp_step);
      end else if (RIDX_W'(i) == REG_SR && ex) begin
        regs_d[i][SR_V] = sr_new[3];
        regs_d[i][SR_N] = sr_new[2];
        regs_d[i][SR_Z] = sr_new[1];
        regs_d[i][SR_C] = sr_new[0];
      end
    end

    if (intack) begin
      regs_d[REG_PC] = {isr_vec[DATA_W-1:1], 1'b0};
      regs_d[REG_SR] = '0;
    end

    // Competing updates to one register, or push and pop together
    if ((rw && dst_inc && dst_step != '0) ||
        (rw && src_inc && src_a == dst_a && src_step != '0) ||
        (src_inc && dst_inc && src_a == dst_a) ||
        (sp_dec && sp_inc)) begin
      conflict_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
      regs_q[REG_PC] <= PC_RESET;
      regs_q[REG_SP] <= SP_RESET;
      conflict_q     <= 1'b0;
    end else begin
      regs_q     <= regs_d;
      conflict_q <= conflict_d;
    end
  end

  assign pc       = regs_q[REG_PC];
  assign sp       = regs_q[REG_SP];
  assign rsrc     = regs_q[src_a];
  assign rdst     = regs_q[dst_a];
  assign sr_flags = {regs_q[REG_SR][SR_V], regs_q[REG_SR][SR_N],
                     regs_q[REG_SR][SR_Z], regs_q[REG_SR][SR_C]};
  assign gie      = regs_q[REG_SR][SR_GIE];
  assign conflict = conflict_q;

endmodule

// File: tb/tb_register_file_x.sv
module tb_register_file_x;

  localparam bit [19:0] PC_RST = 20'h0C000;
  localparam bit [19:0] SP_RST = 20'h00400;

  typedef struct {
    bit        rst_n, if_inc, idx_inc, sp_dec, sp_inc, intack, ex;
    bit [3:0]  sr_new, src_a, dst_a;
    bit [1:0]  size;
    bit        src_inc, dst_inc, rw;
    bit [19:0] result, isr_vec;
  } stim_t;

  typedef struct {
    string     tag;
    bit [19:0] pc, sp, rsrc, rdst;
    bit [3:0]  flags;
    bit        gie, conf;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        if_inc = 0, idx_inc = 0, sp_dec = 0, sp_inc = 0, intack = 0, ex = 0;
  logic        src_inc = 0, dst_inc = 0, rw = 0;
  logic [19:0] isr_vec = '0, result = '0;
  logic [3:0]  sr_new = '0, src_a = '0, dst_a = '0;
  logic [1:0]  size = '0;
  logic [19:0] pc, sp, rsrc, rdst;
  logic [3:0]  sr_flags;
  logic        gie, conflict;

  int n_cmp = 0;
  int n_bad = 0;

  exp_t      exp_q[$];
  bit [19:0] m[16];
  bit        mconf;

  register_file_x #(
    .DATA_W(20), .NREG(16), .PC_RESET(PC_RST), .SP_RESET(SP_RST)
  ) dut (
    .clk(clk), .rst(rst_n), .if_inc(if_inc), .idx_inc(idx_inc),
    .sp_dec(sp_dec), .sp_inc(sp_inc), .intack(intack), .isr_vec(isr_vec),
    .ex(ex), .sr_new(sr_new), .src_a(src_a), .dst_a(dst_a), .size(size),
    .src_inc(src_inc), .dst_inc(dst_inc), .rw(rw), .result(result),
    .pc(pc), .sp(sp), .rsrc(rsrc), .rdst(rdst), .sr_flags(sr_flags),
    .gie(gie), .conflict(conflict)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int unsigned eff_size(input bit [1:0] s);
    return (s == 2'd3) ? 1 : int'(s);
  endfunction

  function automatic bit [19:0] auto_step(input int r, input bit [1:0] s);
    int unsigned b;
    if (r == 2 || r == 3) return 20'd0;
    b = (eff_size(s) == 0) ? 1 : (eff_size(s) == 1) ? 2 : 4;
    if (r <= 1 && b == 1) b = 2;
    return 20'(b);
  endfunction

  function automatic bit [19:0] wb_value(input int r, input bit [1:0] s, input bit [19:0] res);
    bit [19:0] v;
    case (eff_size(s))
      0:       v = res & 20'h000FF;
      1:       v = res & 20'h0FFFF;
      default: v = res;
    endcase
    if (r <= 1) v = v & 20'hFFFFE;
    if (r == 2) v = v & 20'h001FF;
    return v;
  endfunction

  function automatic void model_reset();
    foreach (m[i]) m[i] = 20'd0;
    m[0] = PC_RST;
    m[1] = SP_RST;
    mconf = 1'b0;
  endfunction

  // Lowest-priority updates applied first, each higher one overwrites
  function automatic void model_update(input stim_t s);
    bit [19:0] n[16];
    int        sa, da;
    n  = m;
    sa = int'(s.src_a);
    da = int'(s.dst_a);
    if (s.if_inc || s.idx_inc) n[0] = m[0] + 20'd2;
    if (s.sp_dec && !s.sp_inc) n[1] = m[1] - ((s.size == 2'd2) ? 20'd4 : 20'd2);
    if (s.sp_inc && !s.sp_dec) n[1] = m[1] + ((s.size == 2'd2) ? 20'd4 : 20'd2);
    if (s.ex) begin
      n[2][8] = s.sr_new[3];
      n[2][2] = s.sr_new[2];
      n[2][1] = s.sr_new[1];
      n[2][0] = s.sr_new[0];
    end
    if (s.src_inc && auto_step(sa, s.size) != 0) n[sa] = m[sa] + auto_step(sa, s.size);
    if (s.dst_inc && auto_step(da, s.size) != 0) n[da] = m[da] + auto_step(da, s.size);
    if (s.rw && da != 3) n[da] = wb_value(da, s.size, s.result);
    if (s.intack) begin
      n[0] = s.isr_vec & 20'hFFFFE;
      n[2] = 20'd0;
    end
    if (s.rw && s.dst_inc && auto_step(da, s.size) != 0) mconf = 1'b1;
    if (s.rw && s.src_inc && sa == da && auto_step(sa, s.size) != 0) mconf = 1'b1;
    if (s.src_inc && s.dst_inc && sa == da) mconf = 1'b1;
    if (s.sp_dec && s.sp_inc) mconf = 1'b1;
    m = n;
  endfunction

  // ---------------- driver ----------------
  function automatic stim_t idle();
    stim_t s;
    s = '{default: '0};
    s.rst_n = 1'b1;
    return s;
  endfunction

  task automatic cyc(input stim_t s, input string tag);
    exp_t e;
    rst_n = s.rst_n; if_inc = s.if_inc; idx_inc = s.idx_inc;
    sp_dec = s.sp_dec; sp_inc = s.sp_inc; intack = s.intack; ex = s.ex;
    sr_new = s.sr_new; src_a = s.src_a; dst_a = s.dst_a; size = s.size;
    src_inc = s.src_inc; dst_inc = s.dst_inc; rw = s.rw;
    result = s.result; isr_vec = s.isr_vec;
    if (!s.rst_n) model_reset();
    e.tag   = tag;
    e.pc    = m[0];
    e.sp    = m[1];
    e.rsrc  = m[s.src_a];
    e.rdst  = m[s.dst_a];
    e.flags = {m[2][8], m[2][2], m[2][1], m[2][0]};
    e.gie   = m[2][3];
    e.conf  = mconf;
    exp_q.push_back(e);
    @(posedge clk);
    if (s.rst_n) model_update(s);
    #1;
  endtask

  function automatic stim_t rand_stim();
    stim_t s;
    s = idle();
    s.rst_n   = ($urandom_range(0, 99) >= 3);
    s.if_inc  = ($urandom_range(0, 99) < 30);
    s.idx_inc = ($urandom_range(0, 99) < 15);
    s.sp_dec  = ($urandom_range(0, 99) < 15);
    s.sp_inc  = ($urandom_range(0, 99) < 15);
    s.intack  = ($urandom_range(0, 99) < 5);
    s.ex      = ($urandom_range(0, 99) < 30);
    s.src_inc = ($urandom_range(0, 99) < 20);
    s.dst_inc = ($urandom_range(0, 99) < 20);
    s.rw      = ($urandom_range(0, 99) < 30);
    s.sr_new  = 4'($urandom_range(0, 15));
    s.src_a   = 4'($urandom_range(0, 15));
    s.dst_a   = 4'($urandom_range(0, 15));
    s.size    = 2'($urandom_range(0, 3));
    s.result  = 20'($urandom);
    s.isr_vec = 20'($urandom);
    return s;
  endfunction

  initial begin
    stim_t s;
    model_reset();
    @(posedge clk);
    #1;
    // reset held, fetch strobe must be ignored
    s = idle(); s.rst_n = 1'b0; s.if_inc = 1'b1;
    cyc(s, "rst_hold0");
    cyc(s, "rst_hold1");
    s = idle(); cyc(s, "rst_rel");
    // byte writeback then byte autoincrement
    s = idle(); s.rw = 1; s.dst_a = 5; s.size = 2'd0; s.result = 20'h0ABCD; cyc(s, "byte_wb");
    s = idle(); s.src_inc = 1; s.src_a = 5; s.size = 2'd0; cyc(s, "byte_inc_r5");
    s = idle(); s.src_inc = 1; s.src_a = 1; s.size = 2'd0; s.dst_a = 5; cyc(s, "byte_inc_sp");
    // address-word and wrap
    s = idle(); s.rw = 1; s.dst_a = 4; s.size = 2'd2; s.result = 20'hFFFFE; cyc(s, "aw_wb");
    s = idle(); s.src_inc = 1; s.src_a = 4; s.size = 2'd2; cyc(s, "aw_wrap");
    s = idle(); s.rw = 1; s.dst_a = 1; s.size = 2'd2; s.result = 20'h00100; s.src_a = 4; cyc(s, "sp_set");
    s = idle(); s.sp_dec = 1; s.size = 2'd2; cyc(s, "sp_push_a");
    // SR handling
    s = idle(); s.ex = 1; s.sr_new = 4'b1010; cyc(s, "sr_ex");
    s = idle(); s.rw = 1; s.dst_a = 2; s.size = 2'd1; s.result = 20'h0FFFF; cyc(s, "sr_wb");
    s = idle(); s.rw = 1; s.dst_a = 2; s.size = 2'd1; s.result = 20'h000F7; s.ex = 1; s.sr_new = 4'b1000;
    s.src_a = 2; cyc(s, "sr_rw_vs_ex");
    // interrupt beats fetch and writeback on PC
    s = idle(); s.intack = 1; s.isr_vec = 20'h0F0F1; s.if_inc = 1; s.rw = 1; s.dst_a = 0;
    s.result = 20'h01234; s.size = 2'd1; s.src_a = 2; cyc(s, "intack");
    // conflicts
    s = idle(); s.rw = 1; s.dst_inc = 1; s.dst_a = 7; s.size = 2'd1; s.result = 20'h01234; cyc(s, "rw_dinc");
    s = idle(); s.dst_a = 7; cyc(s, "conf_set");
    s = idle(); s.rw = 1; s.dst_a = 3; s.size = 2'd1; s.result = 20'h0FFFF; cyc(s, "cg2_wb");
    s = idle(); s.src_a = 3; cyc(s, "conf_sticky");
    s = idle(); s.sp_dec = 1; s.sp_inc = 1; cyc(s, "push_pop");
    s = idle(); s.rst_n = 1'b0; cyc(s, "conf_clr");
    s = idle(); s.sp_inc = 1; s.sp_dec = 0; s.size = 2'd1; cyc(s, "pop_after_rst");
    s = idle(); s.src_inc = 1; s.dst_inc = 1; s.src_a = 9; s.dst_a = 9; s.size = 2'd1; cyc(s, "sinc_dinc");
    s = idle(); s.src_a = 9; cyc(s, "sinc_dinc_chk");
    // randomized traffic
    for (int k = 0; k < 600; k++) begin
      s = rand_stim();
      cyc(s, "rnd");
    end
    s = idle(); cyc(s, "final");
    @(negedge clk);
    #1;
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL queue_drain got=%0d pending exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // ---------------- monitor ----------------
  function automatic void chk(input string tag, input string fld,
                              input logic [19:0] got, input bit [19:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s.%s got=%05h exp=%05h", tag, fld, got, want);
    end
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk(e.tag, "pc",       pc,                  e.pc);
      chk(e.tag, "sp",       sp,                  e.sp);
      chk(e.tag, "rsrc",     rsrc,                e.rsrc);
      chk(e.tag, "rdst",     rdst,                e.rdst);
      chk(e.tag, "sr_flags", 20'(sr_flags),       20'(e.flags));
      chk(e.tag, "gie",      20'(gie),            20'(e.gie));
      chk(e.tag, "conflict", 20'(conflict),       20'(e.conf));
    end
  end

endmodule

// File: doc/register_file_x.md
Name: register_file_x

Overview:
- Parametrised successor to the CPU register file for the MSP430X-style core.
- Holds NREG general registers of DATA_W bits (R0 PC, R1 SP, R2 SR, R3 CG2), with two asynchronous read ports and one writeback port.
- Adds three things:
  - Operand sizes byte / word / address-word (20-bit).
  - Size-aware autoincrement plus SP push/pop stepping.
  - A defined per-register update priority and a sticky conflict flag.
- Sits between decode/sequencer (control strobes) and the ALU/MDB (operands, results).

Parameters:
- DATA_W, 20, register width; legal 16 or 20.
- NREG, 16, register count; index width is clog2(NREG).
- PC_RESET, 0, PC value on reset.
- SP_RESET, 0, SP value on reset.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- if_inc  input  1  instruction fetch; PC += 2.
- idx_inc  input  1  index/immediate fetch; PC += 2.
- sp_dec  input  1  push; SP -= step.
- sp_inc  input  1  pop; SP += step.
- intack  input  1  interrupt acknowledge.
- isr_vec  input  DATA_W  vector from IVT.
- ex  input  1  execute; latch flags.
- sr_new  input  4  {V,N,Z,C}.
- src_a  input  4  source register select.
- dst_a  input  4  destination register select.
- size  input  2  00 byte, 01 word, 10 address-word, 11 treated as 01.
- src_inc  input  1  source @Rn+ increment.
- dst_inc  input  1  destination autoincrement.
- rw  input  1  writeback strobe.
- result  input  DATA_W  writeback value.
- pc  output  DATA_W  R0.
- sp  output  DATA_W  R1.
- rsrc  output  DATA_W  R[src_a].
- rdst  output  DATA_W  R[dst_a].
- sr_flags  output  4  {V,N,Z,C}.
- gie  output  1  SR.GIE (bit 3).
- conflict  output  1  sticky update-conflict flag.

Behaviour:
- Reset (rst low, async):
  - All registers 0, except PC = PC_RESET and SP = SP_RESET.
  - conflict = 0.
  - Outputs follow immediately: pc=PC_RESET, sp=SP_RESET, rsrc/rdst per select, sr_flags=0, gie=0.
  - Reset released mid-cycle: the first capture is the next rising edge.
- Reads are combinational from the flops. No bypass: a value written at edge k is visible after edge k.
- SR bit map: C=0, Z=1, N=2, GIE=3, V=8.
- Size rules for writeback:
  - byte: {0, result[7:0]}
  - word: {0, result[15:0]}
  - address-word: result[DATA_W-1:0]
  - With DATA_W=16, address-word equals word.
- Register-specific writeback:
  - PC, SP: bit0 forced 0 after size masking.
  - SR: bits above 8 forced 0.
  - R3 (CG2): writes ignored.
- Increment steps:
  - Autoincrement step: byte +1, word +2, address-word +4.
  - PC and SP never step by 1; byte mode uses +2 for them.
  - SR and R3 are never incremented.
  - SP push/pop step: 4 if size=10, else 2.
- All arithmetic is modulo 2^DATA_W; wrap-around is silent (e.g. SP=0, push word gives 2^DATA_W-2).
- Per-register priority at each edge, highest first:
  1. intack: PC <= {isr_vec[DATA_W-1:1],0} and SR <= 0. This overrides everything else on PC/SR.
  2. rw to that register.
  3. dst_inc on dst_a.
  4. src_inc on src_a.
  5. Implicit updates:
     - PC: if_inc|idx_inc, a single +2 even if both are set.
     - SP: sp_dec/sp_inc.
     - SR: ex writes {V,N,Z,C}; other SR bits are held.
- Simultaneous events:
  - Different registers update independently in the same edge.
  - sp_dec and sp_inc together: SP unchanged, conflict set.
- conflict is set, and stays set until reset, when any of these occur at one edge:
  - rw and (src_inc or dst_inc) target the same incrementable register;
  - src_inc and dst_inc with src_a == dst_a;
  - sp_dec & sp_inc.
  - intack overriding another PC/SR update does not set conflict.

Decomposition:
- Shared parameters package (extend existing global params include):
  - register indices PC, SP, SR, CG1, CG2;
  - SR bit positions;
  - size encodings SZ_B, SZ_W, SZ_A.
- One natural sub-module: rf_step_calc, a combinational block mapping (reg index, size, role) to step and masked writeback value. It is instantiated for the src, dst and SP paths.

Test Plan:
- Reset: hold rst low with PC_RESET=16'hC000 and SP_RESET=16'h0400 → pc=C000, sp=0400, all reads 0, conflict=0. Pulse if_inc while rst is low → pc stays C000.
- Byte writeback, then byte autoincrement:
  - rw, dst_a=5, size=00, result=0xABCD → R5=0x000CD.
  - Then src_inc, src_a=5, size=00 → R5=0x000CE.
  - Then src_inc, src_a=1, size=00 → SP+2.
- Address-word, DATA_W=20:
  - rw, dst_a=4, size=10, result=0xFFFFE → R4=0xFFFFE.
  - Then src_inc → R4=0x00002 (wrap).
  - sp_dec with size=10 from SP=0x00100 → 0x000FC.
- SR writes:
  - ex with sr_new=4'b1010 → sr_flags=1010, gie unchanged.
  - rw, dst_a=2, result=0xFFFF → SR=0x01FF, gie=1.
  - Same edge with ex=1 → rw value wins.
- Interrupt: intack with isr_vec=0x0F0F1 plus if_inc and rw to PC → pc=0x0F0F0, SR=0, conflict stays 0.
- Conflicts:
  - rw and dst_inc both on R7, result=0x1234 → R7=0x1234, conflict=1.
  - conflict persists until rst low.
  - rw to R3 → R3 stays 0.
